vector_floating_point_sign_injection_sequencer: RTL and testbench

- Sequences one vfsgnj/vfsgnjn/vfsgnjx instruction (.vv or .vf form) across an LMUL register group.
- For each active register it reads operands from the vector register file and drives the combinational vector_floating_point_sign_injection_unit. It then writes the result back with mask, tail and vl handling.
- Sits between vector issue and the VRF; the unit itself stays purely combinational.

---
 rtl/vector_floating_point_sign_injection_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_vector_floating_point_sign_injection_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_floating_point_sign_injection_sequencer.sv
// Sequences one vfsgnj/vfsgnjn/vfsgnjx instruction over an LMUL register group:
// reads vs2/vs1 from the VRF, drives the combinational sign-injection unit, writes vd back.
module vector_floating_point_sign_injection_sequencer #(
    parameter int VLEN     = 64,
    parameter int MAX_LMUL = 8,
    parameter int VL_WIDTH = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic [1:0]               request_operation,
    input  logic                     request_sew,
    input  logic [1:0]               request_lmul,
    input  logic [VL_WIDTH-1:0]      request_vl,
    input  logic                     request_vm,
    input  logic [4:0]               request_vs1_address,
    input  logic [4:0]               request_vs2_address,
    input  logic [4:0]               request_vd_address,
    input  logic                     request_scalar_form,
    input  logic [63:0]              request_scalar,
    input  logic [VLEN*MAX_LMUL-1:0] mask,
    output logic [4:0]               read_address_a,
    output logic [4:0]               read_address_b,
    input  logic [VLEN-1:0]          read_data_a,
    input  logic [VLEN-1:0]          read_data_b,
    output logic [3:0]               execution_vector,
    output logic [VLEN-1:0]          unit_vs2,
    output logic [VLEN-1:0]          unit_vs1,
    input  logic [VLEN-1:0]          unit_vd,
    output logic                     write_enable,
    output logic [4:0]               write_address,
    output logic [VLEN-1:0]          write_data,
    output logic [VLEN/8-1:0]        write_byte_enable,
    output logic                     done_valid,
    output logic                     done_illegal
);

    localparam int E32     = VLEN / 32;
    localparam int E64     = VLEN / 64;
    localparam int E32_LOG = $clog2(E32);
    localparam int E64_LOG = $clog2(E64);
    localparam int REG_W   = $clog2(MAX_LMUL);
    localparam int VW1     = VL_WIDTH + 1;
    localparam int MW      = $clog2(VLEN * MAX_LMUL);

    // Encoding understood by the sign-injection unit; all-zero means no operation.
    typedef struct packed {
        logic       active;
        logic [1:0] funct;
        logic       sew64;
    } execution_vector_t;

    localparam execution_vector_t vfsgnj_32  = '{active: 1'b1, funct: 2'b00, sew64: 1'b0};
    localparam execution_vector_t vfsgnj_64  = '{active: 1'b1, funct: 2'b00, sew64: 1'b1};
    localparam execution_vector_t vfsgnjn_32 = '{active: 1'b1, funct: 2'b01, sew64: 1'b0};
    localparam execution_vector_t vfsgnjn_64 = '{active: 1'b1, funct: 2'b01, sew64: 1'b1};
    localparam execution_vector_t vfsgnjx_32 = '{active: 1'b1, funct: 2'b10, sew64: 1'b0};
    localparam execution_vector_t vfsgnjx_64 = '{active: 1'b1, funct: 2'b10, sew64: 1'b1};

    typedef enum logic [2:0] {IDLE, CHECK, READ, EXECUTE, WRITE} state_e;

    state_e             state_q, state_d;
    logic [REG_W-1:0]   reg_q, reg_d;
    logic [1:0]         op_q;
    logic               sew_q;
    logic [1:0]         lmul_q;
    logic [VL_WIDTH-1:0] vl_q;
    logic               vm_q;
    logic [4:0]         vs1_q, vs2_q, vd_q;
    logic               scalar_form_q;
    logic [63:0]        scalar_q;
    logic [VLEN-1:0]    wdata_q;

    logic               accept;
    logic               out_en;
    logic [3:0]         group_regs;
    logic [4:0]         align_mask;
    logic               misaligned;
    logic [VW1-1:0]     vl_max;
    logic               illegal;
    logic               vl_zero;
    logic [VW1-1:0]     active_regs;
    logic               last_reg;
    execution_vector_t  ev_sel;
    logic [VLEN-1:0]    scalar_vec;
    logic [VLEN/8-1:0]  byte_enable;

    assign out_en = !reset;
    assign accept = (state_q == IDLE) && request_valid;

    // Group geometry and legality of the latched instruction.
    assign group_regs  = 4'd1 << lmul_q;
    assign align_mask  = 5'(group_regs) - 5'd1;
    assign misaligned  = (|(vs2_q & align_mask)) || (|(vd_q & align_mask)) ||
                         (!scalar_form_q && (|(vs1_q & align_mask)));
    assign vl_max      = sew_q ? (VW1'(E64) << lmul_q) : (VW1'(E32) << lmul_q);
    assign illegal     = (op_q == 2'b11) || misaligned || ({1'b0, vl_q} > vl_max);
    assign vl_zero     = (vl_q == '0);
    assign active_regs = sew_q ? (({1'b0, vl_q} + VW1'(E64 - 1)) >> E64_LOG)
                               : (({1'b0, vl_q} + VW1'(E32 - 1)) >> E32_LOG);
    assign last_reg    = (VW1'(reg_q) + VW1'(1)) >= active_regs;

    assign scalar_vec  = sew_q ? {E64{scalar_q}} : {E32{scalar_q[31:0]}};

    // Per 32-bit lane: the element it belongs to is active and not masked off.
    for (genvar k = 0; k < E32; k++) begin : g_lane
        logic [MW-1:0] g32, g64;
        logic          on32, on64;
        assign g32  = (MW'(reg_q) << E32_LOG) + MW'(k);
        assign g64  = (MW'(reg_q) << E64_LOG) + MW'(k / 2);
        assign on32 = (g32 < MW'(vl_q)) && (vm_q || mask[g32]);
        assign on64 = (g64 < MW'(vl_q)) && (vm_q || mask[g64]);
        assign byte_enable[k*4 +: 4] = {4{sew_q ? on64 : on32}};
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ev_sel = '0;
        case ({op_q, sew_q})
            3'b000:  ev_sel = vfsgnj_32;
            3'b001:  ev_sel = vfsgnj_64;
            3'b010:  ev_sel = vfsgnjn_32;
            3'b011:  ev_sel = vfsgnjn_64;
            3'b100:  ev_sel = vfsgnjx_32;
            3'b101:  ev_sel = vfsgnjx_64;
            default: ev_sel = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        case (state_q)
            IDLE:    if (request_valid) state_d = CHECK;
            CHECK: begin
                if (illegal || vl_zero) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                    reg_d   = '0;
                end
            end
            READ:    state_d = EXECUTE;
            EXECUTE: state_d = WRITE;
            WRITE: begin
                if (last_reg) begin
                    state_d = IDLE;
                end else begin
                    state_d = READ;
                    reg_d   = reg_q + REG_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            reg_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
        end
    end

    // NOTE: request fields and write data carry no reset; every output they feed is gated by state.
    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            op_q          <= request_operation;
            sew_q         <= request_sew;
            lmul_q        <= request_lmul;
            vl_q          <= request_vl;
            vm_q          <= request_vm;
            vs1_q         <= request_vs1_address;
            vs2_q         <= request_vs2_address;
            vd_q          <= request_vd_address;
            scalar_form_q <= request_scalar_form;
            scalar_q      <= request_scalar;
        end
        if (state_q == EXECUTE) begin
            wdata_q <= unit_vd;
        end
    end

    always_comb begin
        request_ready     = 1'b0;
        execution_vector  = '0;
        read_address_a    = '0;
        read_address_b    = '0;
        unit_vs2          = '0;
        unit_vs1          = '0;
        write_enable      = 1'b0;
        write_address     = '0;
        write_data        = '0;
        write_byte_enable = '0;
        done_valid        = 1'b0;
        done_illegal      = 1'b0;
        if (out_en) begin
            request_ready = (state_q == IDLE);
            if (state_q != IDLE) execution_vector = ev_sel;
            case (state_q)
                CHECK: begin
                    done_valid   = illegal || vl_zero;
                    done_illegal = illegal;
                end
                READ: begin
                    read_address_a = vs2_q + 5'(reg_q);
                    if (!scalar_form_q) read_address_b = vs1_q + 5'(reg_q);
                end
                EXECUTE: begin
                    unit_vs2 = read_data_a;
                    unit_vs1 = scalar_form_q ? scalar_vec : read_data_b;
                end
                WRITE: begin
                    write_enable      = 1'b1;
                    write_address     = vd_q + 5'(reg_q);
                    write_data        = wdata_q;
                    write_byte_enable = byte_enable;
                    done_valid        = last_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_floating_point_sign_injection_sequencer.sv
// Directed bench: bench-side VRF and sign-injection unit model, hand-computed expected writes.
module tb_vector_floating_point_sign_injection_sequencer;

    logic         clock = 1'b0;
    logic         reset;
    logic         request_valid;
    logic         request_ready;
    logic [1:0]   request_operation;
    logic         request_sew;
    logic [1:0]   request_lmul;
    logic [5:0]   request_vl;
    logic         request_vm;
    logic [4:0]   request_vs1_address, request_vs2_address, request_vd_address;
    logic         request_scalar_form;
    logic [63:0]  request_scalar;
    logic [511:0] mask;
    logic [4:0]   read_address_a, read_address_b;
    logic [63:0]  read_data_a, read_data_b;
    logic [3:0]   execution_vector;
    logic [63:0]  unit_vs2, unit_vs1, unit_vd;
    logic         write_enable;
    logic [4:0]   write_address;
    logic [63:0]  write_data;
    logic [7:0]   write_byte_enable;
    logic         done_valid, done_illegal;

    logic [63:0]  vrf [32];
    int           vectors = 0;
    int           miscompares = 0;

    int           n_wr, n_done, done_cyc;
    int           wr_cyc  [8];
    logic [4:0]   wr_addr [8];
    logic [63:0]  wr_data [8];
    logic [7:0]   wr_be   [8];
    logic         done_ill, done_we, ready_c1;
    logic [4:0]   rda_or, rdb_or, rda_c2;
    logic [3:0]   ev_c2;

    vector_floating_point_sign_injection_sequencer #(.VLEN(64), .MAX_LMUL(8), .VL_WIDTH(6)) dut (
        .clock(clock), .reset(reset),
        .request_valid(request_valid), .request_ready(request_ready),
        .request_operation(request_operation), .request_sew(request_sew),
        .request_lmul(request_lmul), .request_vl(request_vl), .request_vm(request_vm),
        .request_vs1_address(request_vs1_address), .request_vs2_address(request_vs2_address),
        .request_vd_address(request_vd_address), .request_scalar_form(request_scalar_form),
        .request_scalar(request_scalar), .mask(mask),
        .read_address_a(read_address_a), .read_address_b(read_address_b),
        .read_data_a(read_data_a), .read_data_b(read_data_b),
        .execution_vector(execution_vector), .unit_vs2(unit_vs2), .unit_vs1(unit_vs1),
        .unit_vd(unit_vd), .write_enable(write_enable), .write_address(write_address),
        .write_data(write_data), .write_byte_enable(write_byte_enable),
        .done_valid(done_valid), .done_illegal(done_illegal)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        read_data_a <= vrf[read_address_a];
        read_data_b <= vrf[read_address_b];
    end

    function automatic logic new_sign(input logic [1:0] f, input logic a, input logic b);
        case (f)
            2'b00:   return b;
            2'b01:   return ~b;
            2'b10:   return a ^ b;
            default: return a;
        endcase
    endfunction

    // Reference sign-injection unit: ev = {active, funct[1:0], sew64}.
    function automatic logic [63:0] sgn_unit(input logic [3:0] ev, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        r = a;
        if (!ev[3]) return 64'h0;
        if (ev[0]) begin
            r[63] = new_sign(ev[2:1], a[63], b[63]);
        end else begin
            r[63] = new_sign(ev[2:1], a[63], b[63]);
            r[31] = new_sign(ev[2:1], a[31], b[31]);
        end
        return r;
    endfunction

    assign unit_vd = sgn_unit(execution_vector, unit_vs2, unit_vs1);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic sew, input logic [1:0] lmul,
                         input logic [5:0] vl, input logic vm, input logic [4:0] vs1,
                         input logic [4:0] vs2, input logic [4:0] vd, input logic sf,
                         input logic [63:0] scalar);
        int waited;
        waited = 0;
        request_operation   = op;
        request_sew         = sew;
        request_lmul        = lmul;
        request_vl          = vl;
        request_vm          = vm;
        request_vs1_address = vs1;
        request_vs2_address = vs2;
        request_vd_address  = vd;
        request_scalar_form = sf;
        request_scalar      = scalar;
        request_valid       = 1'b1;
        while (!request_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("ready_before_accept", 64'(request_ready), 64'd1);
        @(negedge clock);
        request_valid = 1'b0;
    endtask

    // Record activity for cycles 1..ncycles after the accept cycle; ends at cycle ncycles+1.
    task automatic observe(input int ncycles);
        n_wr = 0; n_done = 0; done_cyc = -1; done_ill = 1'b0; done_we = 1'b0;
        rda_or = '0; rdb_or = '0; rda_c2 = '0; ev_c2 = '0; ready_c1 = 1'b1;
        for (int c = 1; c <= ncycles; c++) begin
            if (c == 1) ready_c1 = request_ready;
            if (c == 2) begin
                rda_c2 = read_address_a;
                ev_c2  = execution_vector;
            end
            rda_or |= read_address_a;
            rdb_or |= read_address_b;
            if (write_enable && n_wr < 8) begin
                wr_cyc[n_wr]  = c;
                wr_addr[n_wr] = write_address;
                wr_data[n_wr] = write_data;
                wr_be[n_wr]   = write_byte_enable;
                n_wr++;
            end
            if (done_valid) begin
                n_done++;
                done_cyc = c;
                done_ill = done_illegal;
                done_we  = write_enable;
            end
            @(negedge clock);
        end
    endtask

    task automatic expect_short_done(input string tag, input logic ill);
        check({tag, "_ndone"}, 64'(n_done), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'd1);
        check({tag, "_illegal"}, 64'(done_ill), 64'(ill));
        check({tag, "_no_write"}, 64'(n_wr), 64'd0);
        check({tag, "_no_read"}, 64'(rda_or | rdb_or), 64'd0);
        check({tag, "_ready_after"}, 64'(request_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (vrf[i]) vrf[i] = 64'h0;
        reset = 1'b1; request_valid = 1'b0; request_operation = '0; request_sew = 1'b0;
        request_lmul = '0; request_vl = '0; request_vm = 1'b1; request_vs1_address = '0;
        request_vs2_address = '0; request_vd_address = '0; request_scalar_form = 1'b0;
        request_scalar = '0; mask = '0;
        repeat (3) @(negedge clock);
        check("reset_no_write", 64'(write_enable), 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("reset_ready", 64'(request_ready), 64'd1);
        check("reset_ev", 64'(execution_vector), 64'd0);
        check("reset_done", 64'(done_valid), 64'd0);

        // 1: vfsgnj.vv SEW32 LMUL1 vl=2
        vrf[1] = 64'h3F800000_40000000;
        vrf[2] = 64'h80000000_00000000;
        issue(2'b00, 1'b0, 2'b00, 6'd2, 1'b1, 5'd2, 5'd1, 5'd3, 1'b0, 64'h0);
        observe(8);
        check("t1_ready_drops", 64'(ready_c1), 64'd0);
        check("t1_ev", 64'(ev_c2), 64'h8);
        check("t1_rd_a", 64'(rda_c2), 64'd1);
        check("t1_rd_b", 64'(rdb_or), 64'd2);
        check("t1_nwr", 64'(n_wr), 64'd1);
        check("t1_wr_cycle", 64'(wr_cyc[0]), 64'd4);
        check("t1_wr_addr", 64'(wr_addr[0]), 64'd3);
        check("t1_wr_data", wr_data[0], 64'hBF800000_40000000);
        check("t1_wr_be", 64'(wr_be[0]), 64'hFF);
        check("t1_done_cycle", 64'(done_cyc), 64'd4);
        check("t1_done_with_write", 64'(done_we), 64'd1);
        check("t1_done_legal", 64'(done_ill), 64'd0);
        check("t1_ready_after", 64'(request_ready), 64'd1);

        // 2: vfsgnjn.vv SEW64 LMUL4 vd=v8 vl=3
        vrf[16] = 64'h40000000_00000000; vrf[20] = 64'h00000000_00000000;
        vrf[17] = 64'hC0080000_00000000; vrf[21] = 64'h80000000_00000000;
        vrf[18] = 64'h3FF00000_00000000; vrf[22] = 64'h80000000_00000000;
        issue(2'b01, 1'b1, 2'b10, 6'd3, 1'b1, 5'd20, 5'd16, 5'd8, 1'b0, 64'h0);
        observe(14);
        check("t2_ev", 64'(ev_c2), 64'hB);
        check("t2_nwr", 64'(n_wr), 64'd3);
        check("t2_addr0", 64'(wr_addr[0]), 64'd8);
        check("t2_addr1", 64'(wr_addr[1]), 64'd9);
        check("t2_addr2", 64'(wr_addr[2]), 64'd10);
        check("t2_cyc0", 64'(wr_cyc[0]), 64'd4);
        check("t2_cyc1", 64'(wr_cyc[1]), 64'd7);
        check("t2_cyc2", 64'(wr_cyc[2]), 64'd10);
        check("t2_data0", wr_data[0], 64'hC0000000_00000000);
        check("t2_data1", wr_data[1], 64'h40080000_00000000);
        check("t2_data2", wr_data[2], 64'h3FF00000_00000000);
        check("t2_be2", 64'(wr_be[2]), 64'hFF);
        check("t2_ndone", 64'(n_done), 64'd1);
        check("t2_done_cycle", 64'(done_cyc), 64'd10);

        // 3: vfsgnjx.vf SEW32 vl=2 masked, mask[1:0]=01
        vrf[4] = 64'h3F800000_3F800000;
        mask = '0; mask[0] = 1'b1;
        issue(2'b10, 1'b0, 2'b00, 6'd2, 1'b0, 5'd7, 5'd4, 5'd5, 1'b1, 64'h00000000_80000000);
        observe(8);
        check("t3_ev", 64'(ev_c2), 64'hC);
        check("t3_port_b_unused", 64'(rdb_or), 64'd0);
        check("t3_nwr", 64'(n_wr), 64'd1);
        check("t3_addr", 64'(wr_addr[0]), 64'd5);
        check("t3_data", wr_data[0], 64'hBF800000_BF800000);
        check("t3_be", 64'(wr_be[0]), 64'h0F);
        mask = '0;

        // 4: vfsgnj.vv SEW32 LMUL2 vl=3 -> tail in second register
        vrf[2] = 64'h3F800000_3F800000; vrf[6] = 64'hFFFFFFFF_00000000;
        vrf[3] = 64'h40000000_C0000000; vrf[7] = 64'h00000000_80000000;
        issue(2'b00, 1'b0, 2'b01, 6'd3, 1'b1, 5'd6, 5'd2, 5'd10, 1'b0, 64'h0);
        observe(10);
        check("t4_nwr", 64'(n_wr), 64'd2);
        check("t4_addr1", 64'(wr_addr[1]), 64'd11);
        check("t4_be0", 64'(wr_be[0]), 64'hFF);
        check("t4_be1", 64'(wr_be[1]), 64'h0F);
        check("t4_data0", wr_data[0], 64'hBF800000_3F800000);
        check("t4_data1", wr_data[1], 64'h40000000_C0000000);
        check("t4_done_cycle", 64'(done_cyc), 64'd7);

        // 5: illegal and empty instructions complete one cycle after accept
        issue(2'b11, 1'b0, 2'b00, 6'd1, 1'b1, 5'd2, 5'd1, 5'd3, 1'b0, 64'h0);
        observe(6);
        expect_short_done("t5_op11", 1'b1);
        issue(2'b00, 1'b0, 2'b01, 6'd2, 1'b1, 5'd4, 5'd6, 5'd3, 1'b0, 64'h0);
        observe(6);
        expect_short_done("t5_misaligned_vd", 1'b1);
        issue(2'b00, 1'b1, 2'b00, 6'd2, 1'b1, 5'd4, 5'd6, 5'd3, 1'b0, 64'h0);
        observe(6);
        expect_short_done("t5_vl_over_max", 1'b1);
        issue(2'b00, 1'b0, 2'b00, 6'd0, 1'b1, 5'd4, 5'd6, 5'd3, 1'b0, 64'h0);
        observe(6);
        expect_short_done("t5_vl_zero", 1'b0);

        // 6: reset during EXECUTE of register 1 in an LMUL4 group
        issue(2'b00, 1'b1, 2'b10, 6'd4, 1'b1, 5'd16, 5'd12, 5'd20, 1'b0, 64'h0);
        observe(5);
        check("t6_writes_before_reset", 64'(n_wr), 64'd1);
        check("t6_exec_no_write", 64'(write_enable), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t6_ready_after_reset", 64'(request_ready), 64'd1);
        observe(10);
        check("t6_no_write_after_reset", 64'(n_wr), 64'd0);
        check("t6_no_done_after_reset", 64'(n_done), 64'd0);
        vrf[1] = 64'h3F800000_40000000;
        vrf[2] = 64'h80000000_00000000;
        issue(2'b00, 1'b0, 2'b00, 6'd2, 1'b1, 5'd2, 5'd1, 5'd3, 1'b0, 64'h0);
        observe(8);
        check("t6_new_nwr", 64'(n_wr), 64'd1);
        check("t6_new_cycle", 64'(wr_cyc[0]), 64'd4);
        check("t6_new_data", wr_data[0], 64'hBF800000_40000000);
        check("t6_new_done", 64'(done_cyc), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
